serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_if.sv | 43 ++++
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_if
// Description : Request/result bundle for the bit-serial adder.
//               master drives the request (start, a, b, cin, sub) and reads
//               back the status/result (busy, done, sum, cout, ovf); slave is
//               the adder side of the same bundle.
//   start  request: capture operands and begin an operation
//   a, b   operands, WIDTH bits
//   cin    carry-in (add mode only)
//   sub    0 = a+b+cin, 1 = a-b
//   busy   high while an operation is in progress
//   done   one-cycle pulse, result valid
//   sum    result, held until the next completion
//   cout   carry-out (sub mode: 1 = no borrow)
//   ovf    signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor. One full-adder cell and one carry
//               flip-flop process one bit per clock, LSB first. WIDTH (2..32)
//               operand bits take WIDTH cycles in RUN, followed by a single
//               DONE cycle in which done pulses.
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   bus    serial_adder_if.slave: start/a/b/cin/sub in, busy/done/sum/cout/ovf out
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int                CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  c_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // r_a doubles as the result shift register: each RUN edge consumes a's
    // LSB and shifts the new sum bit in at the top.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_capture;

    // Single full-adder cell
    assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    assign w_last    = (r_state == RUN) && (r_cnt == c_LAST);
    // start is ignored while RUN is in progress
    assign w_capture = bus.start && (r_state != RUN);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = bus.start ? RUN : IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_capture) begin
            r_a     <= bus.a;
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= {w_s, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + c_ONE;
            if (w_last) begin
                r_sum  <= {w_s, r_a[WIDTH-1:1]};
                r_cout <= w_c;
                // r_carry is the carry into the MSB at this edge
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = (r_state == DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. Instances at WIDTH=8
//               (directed scenarios), WIDTH=4 and WIDTH=2 (exhaustive). Each
//               started operation pushes its expected result onto a queue;
//               the entry is popped and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();
    serial_adder_if #(.WIDTH(2)) bus2 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    // Behavioural reference: wide addition plus sign-rule overflow
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [31:0] mask;
        logic [31:0] bb;
        logic [63:0] full;
        exp_t        e;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bb     = sub ? (~b & mask) : (b & mask);
        full   = 64'(a & mask) + 64'(bb) + 64'(sub ? 1'b1 : cin);
        e.sum  = full[31:0] & mask;
        e.cout = full[w];
        e.ovf  = (a[w-1] == bb[w-1]) && (e.sum[w-1] != a[w-1]);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge right after the capture edge.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic sub);
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.sub   = sub;
        bus8.start = 1'b1;
        q8.push_back(model(8, 32'(a), 32'(b), cin, sub));
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    // Observes (does not judge) latency, busy cycles and sum stability.
    task automatic wait_done8(output int lat, output int busy_n, output bit sum_moved);
        logic [7:0] s0;
        s0        = bus8.sum;
        lat       = -1;
        busy_n    = 0;
        sum_moved = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus8.done) begin
                lat = k;
                break;
            end
            if (bus8.busy) busy_n++;
            if (bus8.sum !== s0) sum_moved = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.sub = 1'b0;
        bus4.start = 1'b1; bus4.a = 4'hF;  bus4.b = 4'hF;  bus4.cin = 1'b1; bus4.sub = 1'b0;
        bus2.start = 1'b1; bus2.a = 2'h3;  bus2.b = 2'h3;  bus2.cin = 1'b1; bus2.sub = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_w8: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf);
        end
        n_checks++;
        if ({bus4.busy, bus4.done, bus2.busy, bus2.done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_w4_w2: busy4=%b done4=%b busy2=%b done2=%b, expected 0",
                     bus4.busy, bus4.done, bus2.busy, bus2.done);
        end
        bus8.start = 1'b0; bus4.start = 1'b0; bus2.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_table8(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic cin, input logic sub);
        int   lat;
        int   busy_n;
        bit   moved;
        exp_t e;
        launch8(a, b, cin, sub);
        bus8.a = ~a; bus8.b = ~b; bus8.cin = ~cin; bus8.sub = ~sub;
        wait_done8(lat, busy_n, moved);
        n_checks++;
        if (lat != 8 || busy_n != 8 || moved) begin
            n_fail++;
            $display("FAIL %s_timing: latency=%0d busy_cycles=%0d sum_moved=%0b, expected 8 8 0",
                     name, lat, busy_n, moved);
        end
        n_checks++;
        e = q8.pop_front();
        if ({bus8.ovf, bus8.cout, bus8.sum} !== {e.ovf, e.cout, e.sum[7:0]}) begin
            n_fail++;
            $display("FAIL %s: sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     name, bus8.sum, bus8.cout, bus8.ovf, e.sum[7:0], e.cout, e.ovf);
        end
        @(negedge clk);
        n_checks++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done=%b busy=%b one cycle later, expected 0 0",
                     name, bus8.done, bus8.busy);
        end
    endtask

    task automatic test_add();
        run_table8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_table8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
        run_table8("add_00_00_cin", 8'h00, 8'h00, 1'b1, 1'b0);
        // Directed constants cross-check the reference model itself
        n_checks++;
        if (model(8, 32'hFF, 32'h01, 1'b0, 1'b0) !== {1'b0, 1'b1, 32'h00} ||
            model(8, 32'h7F, 32'h01, 1'b0, 1'b0) !== {1'b1, 1'b0, 32'h80}) begin
            n_fail++;
            $display("FAIL add_model: reference disagrees with hand-computed add results");
        end
    endtask

    task automatic test_sub();
        run_table8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1);
        run_table8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);
        n_checks++;
        if (model(8, 32'h05, 32'h07, 1'b1, 1'b1) !== {1'b0, 1'b0, 32'hFE} ||
            model(8, 32'h80, 32'h01, 1'b0, 1'b1) !== {1'b1, 1'b1, 32'h7F}) begin
            n_fail++;
            $display("FAIL sub_model: reference disagrees with hand-computed sub results");
        end
    endtask

    task automatic test_start_in_run();
        int   k;
        exp_t e;
        launch8(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1; bus8.sub = 1'b1;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        k = 0;
        while (!bus8.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        e = q8.pop_front();
        if (!bus8.done) begin
            n_fail++;
            $display("FAIL ignore_start_timeout: done=%b after 20 cycles, expected 1", bus8.done);
        end else if ({bus8.ovf, bus8.cout, bus8.sum} !== {e.ovf, e.cout, e.sum[7:0]}) begin
            n_fail++;
            $display("FAIL ignore_start: sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     bus8.sum, bus8.cout, bus8.ovf, e.sum[7:0], e.cout, e.ovf);
        end
        @(negedge clk);
        n_checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_idle: busy=%b done=%b, expected 0 0", bus8.busy, bus8.done);
        end
    endtask

    task automatic test_back_to_back();
        int   k;
        int   t1;
        int   t2;
        exp_t e;
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b1; bus8.sub = 1'b0; bus8.start = 1'b1;
        q8.push_back(model(8, 32'h10, 32'h20, 1'b1, 1'b0));
        @(negedge clk);
        bus8.a = 8'h50; bus8.b = 8'h60; bus8.cin = 1'b0; bus8.sub = 1'b1;
        q8.push_back(model(8, 32'h50, 32'h60, 1'b0, 1'b1));
        k = 0;
        while (!bus8.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        t1 = cyc;
        n_checks++;
        e = q8.pop_front();
        if (!bus8.done || {bus8.ovf, bus8.cout, bus8.sum} !== {e.ovf, e.cout, e.sum[7:0]}) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b sum=%h cout=%b ovf=%b, expected 1 sum=%h cout=%b ovf=%b",
                     bus8.done, bus8.sum, bus8.cout, bus8.ovf, e.sum[7:0], e.cout, e.ovf);
        end
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'hC3; bus8.b = 8'h3C; bus8.cin = 1'b1; bus8.sub = 1'b0;
        n_checks++;
        if (bus8.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_idle: busy=%b right after done, expected 1", bus8.busy);
        end
        k = 0;
        while (!bus8.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        t2 = cyc;
        n_checks++;
        e = q8.pop_front();
        if (!bus8.done || {bus8.ovf, bus8.cout, bus8.sum} !== {e.ovf, e.cout, e.sum[7:0]}) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b sum=%h cout=%b ovf=%b, expected 1 sum=%h cout=%b ovf=%b",
                     bus8.done, bus8.sum, bus8.cout, bus8.ovf, e.sum[7:0], e.cout, e.ovf);
        end
        n_checks++;
        if (t2 - t1 != 9) begin
            n_fail++;
            $display("FAIL b2b_spacing: done pulses %0d cycles apart, expected 9", t2 - t1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit seen_done;
        launch8(8'h3C, 8'h0F, 1'b0, 1'b0);
        void'(q8.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_clear: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.cout, bus8.ovf);
        end
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus8.done || bus8.sum !== 8'h00) seen_done = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL abort_no_done: done or partial sum seen after abort=%b, expected 0",
                     seen_done);
        end
        run_table8("after_abort", 8'hA5, 8'h5A, 1'b1, 1'b0);
    endtask

    task automatic test_exhaustive_w4();
        int   k;
        exp_t e;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int m = 0; m < 4; m++) begin
                    bus4.a = 4'(ai); bus4.b = 4'(bi);
                    bus4.cin = m[0]; bus4.sub = m[1]; bus4.start = 1'b1;
                    q4.push_back(model(4, 32'(ai), 32'(bi), m[0], m[1]));
                    @(negedge clk);
                    bus4.start = 1'b0;
                    k = 0;
                    while (!bus4.done && k < 10) begin
                        @(negedge clk);
                        k++;
                    end
                    n_checks++;
                    e = q4.pop_front();
                    if (!bus4.done ||
                        {bus4.ovf, bus4.cout, bus4.sum} !== {e.ovf, e.cout, e.sum[3:0]}) begin
                        n_fail++;
                        $display("FAIL w4 a=%h b=%h cin=%b sub=%b: done=%b sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 ai[3:0], bi[3:0], m[0], m[1], bus4.done, bus4.sum, bus4.cout,
                                 bus4.ovf, e.sum[3:0], e.cout, e.ovf);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive_w2();
        int   k;
        exp_t e;
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int m = 0; m < 4; m++) begin
                    bus2.a = 2'(ai); bus2.b = 2'(bi);
                    bus2.cin = m[0]; bus2.sub = m[1]; bus2.start = 1'b1;
                    q2.push_back(model(2, 32'(ai), 32'(bi), m[0], m[1]));
                    @(negedge clk);
                    bus2.start = 1'b0;
                    k = 0;
                    while (!bus2.done && k < 10) begin
                        @(negedge clk);
                        k++;
                    end
                    n_checks++;
                    e = q2.pop_front();
                    if (!bus2.done ||
                        {bus2.ovf, bus2.cout, bus2.sum} !== {e.ovf, e.cout, e.sum[1:0]}) begin
                        n_fail++;
                        $display("FAIL w2 a=%h b=%h cin=%b sub=%b: done=%b sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 ai[1:0], bi[1:0], m[0], m[1], bus2.done, bus2.sum, bus2.cout,
                                 bus2.ovf, e.sum[1:0], e.cout, e.ovf);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_start_in_run();
        test_back_to_back();
        test_reset_abort();
        test_exhaustive_w4();
        test_exhaustive_w2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
